// File: rtl/load_store_unit_if.sv
// Request, data-memory bus and result signals of the load/store unit.
// The unit itself connects through the slave modport; the core/bus side uses master.
interface load_store_unit_if;
    // Valid/ready: a transfer happens on a rising edge where valid && ready; the
    // initiator keeps valid and its payload stable until then.
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        result_valid;
    logic [31:0] result_data;
    logic        access_error;
    logic        misaligned;
    logic        busy;

    modport slave (
        input  req_valid, opcode, funct3, address, store_data, mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output result_valid, result_data, access_error, misaligned, busy
    );

    modport master (
        output req_valid, opcode, funct3, address, store_data, mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  result_valid, result_data, access_error, misaligned, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-transaction load/store unit: lane steering, byte strobes, load extension, bus timeout.
// Optional feature macro MISALIGNED_TRAP_EN: trap misaligned half/word accesses instead of truncating.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    load_store_unit_if.slave    bus,
    output logic [1:0]          state_dbg
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          mis_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;

    logic          is_load;
    logic          is_store;
    logic          req_legal;
    logic          req_mis;
    logic [31:0]   wdata_fmt;
    logic [3:0]    wstrb_fmt;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_fmt;

    // Request decode, done on the live request so IDLE can steer in one cycle.
    always_comb begin
        is_load  = (bus.opcode == OP_LOAD);
        is_store = (bus.opcode == OP_STORE);
        req_legal = 1'b0;
        if (is_load) begin
            case (bus.funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                req_legal = 1'b0;
            endcase
        end else if (is_store) begin
            req_legal = (bus.funct3 < 3'b011);
        end
    end

`ifdef MISALIGNED_TRAP_EN
    assign req_mis = ((bus.funct3[1:0] == 2'b01) && bus.address[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.address[1:0] != 2'b00));
`else
    // Without the trap, half/word accesses simply drop the low address bits.
    assign req_mis = 1'b0;
`endif

    always_comb begin
        wdata_fmt = bus.store_data;
        wstrb_fmt = 4'b1111;
        case (bus.funct3[1:0])
            2'b00: begin
                wdata_fmt = {4{bus.store_data[7:0]}};
                wstrb_fmt = 4'b0001 << bus.address[1:0];
            end
            2'b01: begin
                wdata_fmt = {2{bus.store_data[15:0]}};
                wstrb_fmt = bus.address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_fmt = bus.store_data;
                wstrb_fmt = 4'b1111;
            end
        endcase
    end

    // Load formatting uses the size/lane captured at accept time.
    always_comb begin
        rd_byte = bus.mem_rdata[7:0];
        case (lane_q)
            2'd0:    rd_byte = bus.mem_rdata[7:0];
            2'd1:    rd_byte = bus.mem_rdata[15:8];
            2'd2:    rd_byte = bus.mem_rdata[23:16];
            default: rd_byte = bus.mem_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_fmt = {24'd0, rd_byte};
            3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_fmt = {16'd0, rd_half};
            default: load_fmt = bus.mem_rdata;
        endcase
    end

    assign cnt_inc     = cnt_q + CW'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready    = 1'b0;
        bus.busy         = 1'b1;
        bus.mem_valid    = 1'b0;
        bus.result_valid = 1'b0;
        bus.access_error = 1'b0;
        bus.misaligned   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    state_d = (req_legal && !req_mis) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                bus.mem_valid = 1'b1;
                // A completion arriving on the limit cycle still wins over the timeout.
                if (bus.mem_ready || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.result_valid = 1'b1;
                bus.access_error = err_q;
                bus.misaligned   = mis_q;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        f3_q    <= bus.funct3;
                        lane_q  <= bus.address[1:0];
                        we_q    <= req_legal && is_store;
                        addr_q  <= {bus.address[31:2], 2'b00};
                        wdata_q <= (req_legal && is_store) ? wdata_fmt : 32'd0;
                        wstrb_q <= (req_legal && is_store) ? wstrb_fmt : 4'd0;
                        rdata_q <= 32'd0;
                        err_q   <= !req_legal;
                        mis_q   <= req_legal && req_mis;
                        cnt_q   <= '0;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        if (!we_q) begin
                            rdata_q <= load_fmt;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RESP: begin
                    cnt_q <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
    assign bus.result_data = rdata_q;
    assign state_dbg       = state_q;

endmodule
